uart_rx_param: RTL and testbench
================================

// Module: uart_rx_param
// PURPOSE
//  Parametrised UART receiver; successor to the fixed 8E1 receiver. Oversampled bit recovery;
//  configurable data width, parity mode and stop-bit count. Flags framing, parity, overrun, break.
//  Presents frames on a valid/ready interface to the UART host logic, with a stretched good-frame LED.
// PARAMETERS
//  CLK_FREQ     100_000_000  system clock in Hz
//  BAUD_RATE    9600         line rate in bit/s
//  OVERSAMPLE   16           ticks per bit; even, >=8
//  DATA_BITS    8            data width 5..9
//  PARITY_MODE  1            0=none, 1=even, 2=odd
//  STOP_BITS    1            1 or 2
//  LED_HOLD     5_000_000    LED on-time in clk cycles after a good frame
// PORTS
//  clk           in   1          system clock
//  rst_n         in   1          async active-low reset
//  rx            in   1          serial line, idle high, asynchronous to clk
//  data_out      out  DATA_BITS  received word, LSB first on line
//  rx_valid      out  1          frame available; held until accepted
//  rx_ready      in   1          consumer accepts when rx_valid && rx_ready
//  parity_error  out  1          qualifies data_out; 0 when PARITY_MODE=0
//  frame_error   out  1          qualifies data_out; any stop bit sampled 0
//  break_det     out  1          qualifies data_out; every sample of the frame was 0
//  overrun       out  1          1-cycle pulse; completed frame dropped
//  led           out  1          high LED_HOLD cycles after an error-free accepted-or-pending frame
// BEHAVIOUR
//  Reset (rst_n low, async): all outputs 0; FSM IDLE; counters 0; sync flops 1.
//  Reset mid-frame aborts the frame. Nothing is emitted after release.
//  Sync: rx passes a 2-flop synchronizer. All decisions use the synchronized value rxs.
//  Tick: uart_baud_tick pulses once every DIV = CLK_FREQ/(BAUD_RATE*OVERSAMPLE) clks (integer divide).
//  Counters below advance on ticks only. The divider free-runs and restarts on entry to START.
//  FSM:
//   IDLE  -> START on rxs falling edge (1 then 0).
//   START: at tick OVERSAMPLE/2-1, rxs=1 -> IDLE (glitch, no output); rxs=0 -> DATA. Bit-tick counter clears.
//   DATA: sample every OVERSAMPLE ticks (mid-bit); shift in LSB first.
//     After DATA_BITS samples -> PARITY, or STOP if PARITY_MODE=0.
//   PARITY: one sample. Error if sample != (^data) for even, or != ~(^data) for odd.
//   STOP: STOP_BITS samples. Any 0 sets frame_error. After the last sample -> DONE.
//   DONE (1 clk): load outputs, then -> IDLE. The next start edge is detectable on the following clk.
//  Break: all samples 0, including start, parity and stop. Then break_det=1, frame_error=1, data_out=0.
//  Output: data_out and flags load together with rx_valid=1 in the cycle after DONE.
//   They are stable while rx_valid=1. rx_valid clears the cycle after the handshake.
//   Simultaneous handshake and new DONE: new frame loads and rx_valid stays 1; no overrun.
//   DONE while rx_valid=1 && !rx_ready: new frame discarded; overrun pulses 1 clk; held frame unchanged.
//  LED: error-free frame loaded -> counter = LED_HOLD; led = (counter != 0); counter decrements each clk.
//   A new good frame reloads the counter. An error frame leaves the counter alone.
//  Widths: tick counter $clog2(OVERSAMPLE); bit counter $clog2(DATA_BITS+1); LED counter $clog2(LED_HOLD+1).
// CONFIGURATION
//  UART_RX_MAJORITY_EN defined:
//   each data/parity/stop sample is the 2-of-3 majority of rxs at ticks OVERSAMPLE/2-2, -1, +0.
//   The start check uses the same majority.
//  Undefined: single sample at tick OVERSAMPLE/2-1 of each bit. Frame timing is identical.
// STRUCTURE
//  Package uart_pkg: parity-mode constants (PAR_NONE/PAR_EVEN/PAR_ODD);
//   FSM state encoding (IDLE, START, DATA, PARITY, STOP, DONE); divisor helper function.
//  Sub-module uart_baud_tick: parametrised divider with sync restart input and tick output.
//  Synchronizer, FSM, output register and LED stretcher stay inline.
// TESTING (CLK_FREQ=100e6, BAUD_RATE=115200, OVERSAMPLE=16 -> DIV=54, bit=864 clk)
//  1. 8E1, send 0xA5, parity 0, rx_ready=1:
//     rx_valid 1 clk, data_out=0xA5, all flags 0, led high 5_000_000 clk.
//  2. 8E1, send 0x3C with parity bit 1:
//     data_out=0x3C, parity_error=1, led stays 0. Repeat with PARITY_MODE=2: no error.
//  3. rx low 300 clk then high:
//     START aborts, no rx_valid. A following 0x55 frame is received correctly.
//  4. rx_ready=0, send 0x11 then 0x22:
//     data_out holds 0x11, overrun pulses once. rx_ready=1 -> handshake, rx_valid drops.
//  5. STOP_BITS=2, second stop bit 0, data 0x7E:
//     frame_error=1. Line held low 12 bit-times: break_det=1, frame_error=1, data_out=0x00.
//  6. rst_n low mid-DATA of 0x81, release:
//     outputs all 0, no frame emitted. A next 0x81 is received correctly.
//     With UART_RX_MAJORITY_EN, a 1-clk glitch at mid-bit does not corrupt data.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the parametrised UART receiver.
//  - parity-mode constants (PAR_NONE / PAR_EVEN / PAR_ODD)
//  - receiver FSM state encoding
//  - calc_div(): system clocks per oversample tick (integer divide)
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    DONE
  } uart_state_e;

  function automatic int calc_div(input int clk_freq, input int baud, input int os);
    return clk_freq / (baud * os);
  endfunction

endpackage

// File: rtl/uart_rx_param_if.sv
// Frame hand-off interface between the UART receiver and the host logic.
//  data_out      received word (LSB arrived first on the line)
//  rx_valid      frame available
//  rx_ready      consumer ready
//  parity_error  qualifies data_out
//  frame_error   qualifies data_out
//  break_det     qualifies data_out
//  overrun       1-cycle pulse: a completed frame was dropped
// Handshake: a transfer happens on every rising clk edge where rx_valid && rx_ready.
// Once raised, rx_valid stays high and data_out/flags stay stable until that
// transfer; rx_valid never depends combinationally on rx_ready.
// Modports: master = receiver, slave = consumer.
interface uart_rx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_out;
  logic                 rx_valid;
  logic                 rx_ready;
  logic                 parity_error;
  logic                 frame_error;
  logic                 break_det;
  logic                 overrun;

  modport master (
    output data_out, rx_valid, parity_error, frame_error, break_det, overrun,
    input  rx_ready
  );

  modport slave (
    input  data_out, rx_valid, parity_error, frame_error, break_det, overrun,
    output rx_ready
  );
endinterface

// File: rtl/uart_baud_tick.sv
// Oversample tick generator: tick_o pulses once every DIV clocks.
//  clk, rst_n  clock, async active-low reset
//  restart_i   synchronous restart: counter returns to 0 on the next edge
//  tick_o      1-cycle tick
module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst_n,
  input  logic restart_i,
  output logic tick_o
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (restart_i || (cnt_q == LAST)) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised oversampling UART receiver.
//  clk, rst_n  system clock, async active-low reset
//  rx          serial line (idle high, asynchronous to clk)
//  led         high LED_HOLD cycles after an error-free frame is loaded
//  state_o     FSM state (debug)
//  rx_if       frame hand-off (master modport): data_out, rx_valid, rx_ready,
//              parity_error, frame_error, break_det, overrun
// Build option: UART_RX_MAJORITY_EN -- each bit decision is the 2-of-3 majority
// of rxs at ticks OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2 of the bit;
// otherwise a single sample at tick OVERSAMPLE/2-1.
module uart_rx_param
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE   = 9600,
  parameter int OVERSAMPLE  = 16,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 1,
  parameter int STOP_BITS   = 1,
  parameter int LED_HOLD    = 5_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx,
  output logic        led,
  output uart_state_e state_o,
  uart_rx_param_if.master rx_if
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE, OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam int BW  = $clog2(DATA_BITS + 1);
  localparam int LW  = (LED_HOLD > 0) ? $clog2(LED_HOLD + 1) : 1;

`ifdef UART_RX_MAJORITY_EN
  // The decision is taken on the last of the three samples.
  localparam int SAMPLE_TICK = OVERSAMPLE / 2;
`else
  localparam int SAMPLE_TICK = OVERSAMPLE / 2 - 1;
`endif

  localparam logic [TW-1:0] TK_MID    = TW'(SAMPLE_TICK);
  localparam logic [TW-1:0] TK_BIT    = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] LAST_DATA = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  localparam logic [LW-1:0] LED_MAX   = LW'(LED_HOLD);

  // ---------------- synchronizer and start-edge detect ----------------
  logic rx_meta_q, rxs_q, rxs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q  <= 1'b1;
      rxs_q      <= 1'b1;
      rxs_prev_q <= 1'b1;
    end else begin
      rx_meta_q  <= rx;
      rxs_q      <= rx_meta_q;
      rxs_prev_q <= rxs_q;
    end
  end

  logic fall;
  assign fall = rxs_prev_q & ~rxs_q;

  // ---------------- tick generator ----------------
  logic restart, tick;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk       (clk),
    .rst_n     (rst_n),
    .restart_i (restart),
    .tick_o    (tick)
  );

  // ---------------- bit sample ----------------
  logic sample;

`ifdef UART_RX_MAJORITY_EN
  logic [1:0] hist_q;  // rxs at the previous two ticks

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    hist_q <= 2'b11;
    else if (tick) hist_q <= {hist_q[0], rxs_q};
  end

  assign sample = (hist_q[1] & hist_q[0]) | (hist_q[1] & rxs_q) | (hist_q[0] & rxs_q);
`else
  assign sample = rxs_q;
`endif

  // ---------------- receive FSM ----------------
  uart_state_e          state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [BW-1:0]        bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_err_q, par_err_d;
  logic                 frm_err_q, frm_err_d;
  logic                 all_zero_q, all_zero_d;  // every sample so far was 0

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      tick_cnt_q <= '0;
      bit_cnt_q  <= '0;
      shift_q    <= '0;
      par_err_q  <= 1'b0;
      frm_err_q  <= 1'b0;
      all_zero_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      tick_cnt_q <= tick_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      shift_q    <= shift_d;
      par_err_q  <= par_err_d;
      frm_err_q  <= frm_err_d;
      all_zero_q <= all_zero_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    par_err_d  = par_err_q;
    frm_err_d  = frm_err_q;
    all_zero_d = all_zero_q;
    restart    = 1'b0;

    case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        if (fall) begin
          state_d = START;
          restart = 1'b1;  // align ticks to the start edge
        end
      end

      START: begin
        if (tick) begin
          if (tick_cnt_q == TK_MID) begin
            tick_cnt_d = '0;
            if (sample) begin
              state_d = IDLE;  // glitch, not a start bit
            end else begin
              state_d    = DATA;
              bit_cnt_d  = '0;
              par_err_d  = 1'b0;
              frm_err_d  = 1'b0;
              all_zero_d = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      DATA: begin
        if (tick) begin
          if (tick_cnt_q == TK_BIT) begin
            tick_cnt_d = '0;
            shift_d    = {sample, shift_q[DATA_BITS-1:1]};
            all_zero_d = all_zero_q & ~sample;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_d = '0;
              state_d   = (PARITY_MODE == PAR_NONE) ? STOP : PARITY;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      PARITY: begin
        if (tick) begin
          if (tick_cnt_q == TK_BIT) begin
            tick_cnt_d = '0;
            all_zero_d = all_zero_q & ~sample;
            // Odd: error when the sample equals the plain XOR of the data.
            par_err_d  = (PARITY_MODE == PAR_ODD) ? (sample == ^shift_q)
                                                  : (sample != ^shift_q);
            state_d    = STOP;
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (tick_cnt_q == TK_BIT) begin
            tick_cnt_d = '0;
            all_zero_d = all_zero_q & ~sample;
            frm_err_d  = frm_err_q | ~sample;
            bit_cnt_d  = bit_cnt_q + 1'b1;
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_d = '0;
              state_d   = DONE;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 1'b1;
          end
        end
      end

      DONE: begin
        tick_cnt_d = '0;
        state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign state_o = state_q;

  // ---------------- output register and LED stretcher ----------------
  logic                 done, load, frame_good;
  logic [DATA_BITS-1:0] data_q;
  logic                 valid_q, perr_q, ferr_q, brk_q, ovr_q;
  logic [LW-1:0]        led_cnt_q, led_cnt_d;

  assign done       = (state_q == DONE);
  // A new frame may replace the held one in the same cycle it is accepted.
  assign load       = done && (!valid_q || rx_if.rx_ready);
  assign frame_good = !par_err_q && !frm_err_q && !all_zero_q;

  always_comb begin
    led_cnt_d = led_cnt_q;
    if (load && frame_good)    led_cnt_d = LED_MAX;
    else if (led_cnt_q != '0)  led_cnt_d = led_cnt_q - 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q    <= '0;
      valid_q   <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      brk_q     <= 1'b0;
      ovr_q     <= 1'b0;
      led_cnt_q <= '0;
    end else begin
      led_cnt_q <= led_cnt_d;
      ovr_q     <= done && !load;
      if (load) begin
        valid_q <= 1'b1;
        data_q  <= all_zero_q ? '0 : shift_q;
        perr_q  <= par_err_q;
        ferr_q  <= frm_err_q | all_zero_q;
        brk_q   <= all_zero_q;
      end else if (valid_q && rx_if.rx_ready) begin
        valid_q <= 1'b0;
      end
    end
  end

  assign rx_if.data_out     = data_q;
  assign rx_if.rx_valid     = valid_q;
  assign rx_if.parity_error = perr_q;
  assign rx_if.frame_error  = ferr_q;
  assign rx_if.break_det    = brk_q;
  assign rx_if.overrun      = ovr_q;
  assign led                = (led_cnt_q != '0);

endmodule

// File: tb/tb_uart_rx_param.sv
// Bench for uart_rx_param: two receivers on separate lines,
// A = 8E1 and B = 8O2, both at 1 Mbit/s with 16x oversampling (96 clk per bit).
module tb_uart_rx_param;
  import uart_pkg::*;

  localparam int CLK_FREQ = 100_000_000;
  localparam int BAUD     = 1_000_000;
  localparam int OS       = 16;
  localparam int BIT_CLK  = CLK_FREQ / (BAUD * OS) * OS;
  localparam int LED_HOLD = 300;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  logic rx_a, rx_b, led_a, led_b;
  uart_state_e st_a, st_b;

  always #5 clk = ~clk;

  uart_rx_param_if #(.DATA_BITS(8)) ifa ();
  uart_rx_param_if #(.DATA_BITS(8)) ifb ();

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
    .PARITY_MODE(1), .STOP_BITS(1), .LED_HOLD(LED_HOLD)
  ) dut_a (
    .clk(clk), .rst_n(rst_n), .rx(rx_a), .led(led_a), .state_o(st_a), .rx_if(ifa)
  );

  uart_rx_param #(
    .CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .OVERSAMPLE(OS), .DATA_BITS(8),
    .PARITY_MODE(2), .STOP_BITS(2), .LED_HOLD(LED_HOLD)
  ) dut_b (
    .clk(clk), .rst_n(rst_n), .rx(rx_b), .led(led_b), .state_o(st_b), .rx_if(ifb)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [10:0] exp_qa[$];  // {data, parity_error, frame_error, break_det}
  logic [10:0] exp_qb[$];
  int ovr_a = 0, ovr_b = 0;
  int led_run_a = 0, last_led_run_a = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
    end
  endtask

  task automatic check_frame(input int sel, input logic [10:0] got);
    logic [10:0] exp;
    int sz;
    sz = (sel == 0) ? exp_qa.size() : exp_qb.size();
    n_checks++;
    if (sz == 0) begin
      n_errors++;
      $display("FAIL unexpected_frame dut%0d: got=%h expected=none", sel, got);
    end else begin
      if (sel == 0) exp = exp_qa.pop_front();
      else          exp = exp_qb.pop_front();
      if (got !== exp) begin
        n_errors++;
        $display("FAIL frame dut%0d: got data=%h p/f/b=%b expected data=%h p/f/b=%b",
                 sel, got[10:3], got[2:0], exp[10:3], exp[2:0]);
      end
    end
  endtask

  // Monitor: sample away from the active edge.
  always @(negedge clk) begin
    if (rst_n) begin
      if (ifa.rx_valid && ifa.rx_ready)
        check_frame(0, {ifa.data_out, ifa.parity_error, ifa.frame_error, ifa.break_det});
      if (ifb.rx_valid && ifb.rx_ready)
        check_frame(1, {ifb.data_out, ifb.parity_error, ifb.frame_error, ifb.break_det});
      if (ifa.overrun) ovr_a++;
      if (ifb.overrun) ovr_b++;
      if (led_a) led_run_a++;
      else if (led_run_a != 0) begin
        last_led_run_a = led_run_a;
        led_run_a = 0;
      end
    end
  end

  // ---------------- reference model ----------------
  // Whole-frame view: bits[0]=start, [8:1]=data, [9]=parity, then stop bits.
  function automatic logic [10:0] model(input int sel, input logic [11:0] bits);
    int nbits;
    logic [7:0] d;
    logic perr, ferr, brk;
    nbits = (sel == 0) ? 11 : 12;
    d     = bits[8:1];
    perr  = (sel == 0) ? (bits[9] != (^d)) : (bits[9] != ~(^d));
    ferr  = 1'b0;
    for (int i = 10; i < nbits; i++) if (!bits[i]) ferr = 1'b1;
    brk = 1'b1;
    for (int i = 0; i < nbits; i++) if (bits[i]) brk = 1'b0;
    if (brk) begin
      d    = 8'h00;
      ferr = 1'b1;
    end
    return {d, perr, ferr, brk};
  endfunction

  // ---------------- drivers ----------------
  function automatic logic [11:0] build(input int sel, input logic [7:0] d,
                                        input bit flip, input bit stop_bad);
    logic [11:0] b;
    b      = 12'hFFF;
    b[0]   = 1'b0;
    b[8:1] = d;
    if (sel == 0) begin
      b[9]  = (^d) ^ flip;
      b[10] = ~stop_bad;
    end else begin
      b[9]  = ~(^d) ^ flip;
      b[11] = ~stop_bad;
    end
    return b;
  endfunction

  task automatic set_line(input int sel, input logic v);
    if (sel == 0) rx_a = v;
    else          rx_b = v;
  endtask

  task automatic send_bits(input int sel, input logic [11:0] bits, input int gap);
    int nbits;
    nbits = (sel == 0) ? 11 : 12;
    for (int i = 0; i < nbits; i++) begin
      set_line(sel, bits[i]);
      repeat (BIT_CLK) @(posedge clk);
      #1;
    end
    set_line(sel, 1'b1);
    repeat (gap) @(posedge clk);
    #1;
  endtask

  task automatic wait_drain(input int sel, input int budget);
    int n;
    n = 0;
    while (((sel == 0) ? exp_qa.size() : exp_qb.size()) != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    chk($sformatf("drain_dut%0d", sel), (sel == 0) ? exp_qa.size() : exp_qb.size(), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          sel;
    logic [7:0]  d;
    bit          flip;
    bit          stop_bad;
    logic [10:0] exp;
  } vec_t;

  vec_t tbl[7];

  initial begin
    logic [11:0] bits;
    int          sel, ob;

    tbl[0] = '{0, 8'hA5, 1'b0, 1'b0, {8'hA5, 3'b000}};
    tbl[1] = '{1, 8'h3C, 1'b0, 1'b0, {8'h3C, 3'b000}};  // odd parity bit is 1
    tbl[2] = '{1, 8'h7E, 1'b0, 1'b1, {8'h7E, 3'b010}};  // second stop bit 0
    tbl[3] = '{0, 8'h00, 1'b0, 1'b0, {8'h00, 3'b000}};
    tbl[4] = '{1, 8'hFF, 1'b1, 1'b0, {8'hFF, 3'b100}};
    tbl[5] = '{0, 8'h81, 1'b0, 1'b1, {8'h81, 3'b010}};
    tbl[6] = '{0, 8'hC3, 1'b1, 1'b0, {8'hC3, 3'b100}};

    rst_n = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    ifa.rx_ready = 1'b1;
    ifb.rx_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("reset_valid_a", ifa.rx_valid, 0);
    chk("reset_data_a", ifa.data_out, 0);
    chk("reset_flags_a", {ifa.parity_error, ifa.frame_error, ifa.break_det, ifa.overrun}, 0);
    chk("reset_led_a", led_a, 0);
    chk("reset_state_b", st_b, IDLE);
    rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // Good 8E1 frame: one-cycle valid, LED on for LED_HOLD cycles.
    exp_qa.push_back({8'hA5, 3'b000});
    send_bits(0, build(0, 8'hA5, 1'b0, 1'b0), 20);
    wait_drain(0, 200);
    chk("valid_dropped", ifa.rx_valid, 0);
    chk("led_on", led_a, 1);
    repeat (LED_HOLD + 100) @(posedge clk);
    #1;
    chk("led_hold_len", last_led_run_a, LED_HOLD);
    chk("led_off", led_a, 0);

    // Parity error: flagged, LED untouched.
    exp_qa.push_back({8'h3C, 3'b100});
    send_bits(0, build(0, 8'h3C, 1'b1, 1'b0), 20);
    wait_drain(0, 200);
    chk("led_after_perr", led_a, 0);

    // Table-driven frames.
    for (int i = 0; i < 7; i++) begin
      if (tbl[i].sel == 0) exp_qa.push_back(tbl[i].exp);
      else                 exp_qb.push_back(tbl[i].exp);
      send_bits(tbl[i].sel, build(tbl[i].sel, tbl[i].d, tbl[i].flip, tbl[i].stop_bad), 20);
      wait_drain(tbl[i].sel, 500);
    end

    // Short low pulse: start check rejects it, then a real frame.
    rx_a = 1'b0;
    repeat (30) @(posedge clk);
    #1;
    rx_a = 1'b1;
    repeat (100) @(posedge clk);
    #1;
    chk("glitch_idle", st_a, IDLE);
    chk("glitch_no_valid", ifa.rx_valid, 0);
    exp_qa.push_back({8'h55, 3'b000});
    send_bits(0, build(0, 8'h55, 1'b0, 1'b0), 20);
    wait_drain(0, 200);

    // Overrun: consumer stalled across two frames.
    ifa.rx_ready = 1'b0;
    ob = ovr_a;
    exp_qa.push_back({8'h11, 3'b000});
    send_bits(0, build(0, 8'h11, 1'b0, 1'b0), 20);
    send_bits(0, build(0, 8'h22, 1'b0, 1'b0), 20);
    chk("ovr_valid_held", ifa.rx_valid, 1);
    chk("ovr_data_held", ifa.data_out, 8'h11);
    chk("ovr_pulses", ovr_a - ob, 1);
    ifa.rx_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("ovr_valid_drop", ifa.rx_valid, 0);
    wait_drain(0, 10);

    // Break on the 8O2 receiver: line low 12 bit-times.
    exp_qb.push_back({8'h00, 3'b111});
    rx_b = 1'b0;
    repeat (12 * BIT_CLK) @(posedge clk);
    #1;
    rx_b = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    wait_drain(1, 200);

    // Reset in the middle of the data bits of 0x81.
    bits = build(0, 8'h81, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      rx_a = bits[i];
      repeat ((i == 4) ? BIT_CLK / 2 : BIT_CLK) @(posedge clk);
      #1;
    end
    chk("mid_frame_state", st_a, DATA);
    rst_n = 1'b0;
    rx_a  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("midrst_valid", ifa.rx_valid, 0);
    chk("midrst_state", st_a, IDLE);
    chk("midrst_led", led_a, 0);
    rst_n = 1'b1;
    repeat (3 * BIT_CLK) @(posedge clk);
    #1;
    chk("post_rst_valid", ifa.rx_valid, 0);
    chk("post_rst_state", st_a, IDLE);
    exp_qa.push_back({8'h81, 3'b000});
    send_bits(0, build(0, 8'h81, 1'b0, 1'b0), 20);
    wait_drain(0, 200);

    // Randomized frames against the model.
    for (int i = 0; i < 16; i++) begin
      sel  = $urandom_range(0, 1);
      bits = build(sel, 8'($urandom_range(0, 255)),
                   ($urandom_range(0, 3) == 0), ($urandom_range(0, 4) == 0));
      if (sel == 0) exp_qa.push_back(model(0, bits));
      else          exp_qb.push_back(model(1, bits));
      send_bits(sel, bits, $urandom_range(5, 60));
      wait_drain(sel, 500);
    end

    chk("total_overruns_a", ovr_a, 1);
    chk("total_overruns_b", ovr_b, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Hard time limit so the bench always terminates.
  initial begin
    #5ms;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

endmodule
